if_stage: RTL and testbench

- Instruction-fetch stage of the MIPS datapath, directly upstream of control_unit.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Registers the fetched word into the IF/ID register; control_unit decodes its opcode field.
- Supports downstream stall and branch redirect/flush. Bubbles are delivered as NOP (0x00000000).

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// fills the IF/ID register, with a one-word hold buffer for downstream stalls.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid
);

  typedef enum logic [1:0] {START, FETCH, HOLD} state_t;

  localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc;
  logic              ifid_load, ifid_from_hold, ifid_flush, hold_load;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] src_pc;

  assign target    = branch_target & ALIGN_MASK;
  assign imem_addr = pc;
  assign if_opcode = if_instr[31:26];
  assign src_pc    = ifid_from_hold ? hold_pc : pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= START;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    imem_req       = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_hold = 1'b0;
    ifid_flush     = 1'b0;
    hold_load      = 1'b0;
    unique case (state)
      START: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_next    = target;
          ifid_flush = 1'b1;
        end else if (imem_ready && !stall) begin
          ifid_load = 1'b1;
          pc_next   = pc + FOUR;
        end else if (imem_ready) begin
          // Word already accepted from memory: park it until the stall clears.
          hold_load  = 1'b1;
          pc_next    = pc + FOUR;
          state_next = HOLD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_next    = target;
          ifid_flush = 1'b1;
          state_next = FETCH;
        end else if (!stall) begin
          ifid_load      = 1'b1;
          ifid_from_hold = 1'b1;
          state_next     = FETCH;
        end
      end
      default: state_next = START;
    endcase
  end

  // NOTE: the hold buffer is reset along with everything else so a word
  // parked before reset can never leak out afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      hold_instr  <= '0;
      hold_pc     <= '0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (hold_load) begin
        hold_instr <= imem_rdata;
        hold_pc    <= pc;
      end
      if (ifid_flush) begin
        if_instr <= '0;
        if_valid <= 1'b0;
      end else if (ifid_load) begin
        if_instr    <= ifid_from_hold ? hold_instr : imem_rdata;
        if_pc       <= src_pc;
        if_pc_plus4 <= src_pc + FOUR;
        if_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a scoreboard of expected IF/ID words plus
// point checks for bubbles, stalls, redirects, PC wrap and reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_ready;
  logic [31:0] branch_target;

  logic        imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;
  logic [5:0]  if_opcode;

  logic        w_imem_req, w_if_valid;
  logic [31:0] w_imem_addr, w_imem_rdata, w_if_instr, w_if_pc, w_if_pc_plus4;
  logic [5:0]  w_if_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h8C08_0004;
      32'h4:   return 32'hAC08_0008;
      default: return {6'b001001, addr[27:2]};
    endcase
  endfunction

  assign imem_rdata   = imem_ready ? mem_word(imem_addr)   : 32'hDEAD_BEEF;
  assign w_imem_rdata = imem_ready ? mem_word(w_imem_addr) : 32'hDEAD_BEEF;

  if_stage u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_instr(if_instr),
    .if_opcode(if_opcode), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_valid(if_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(w_imem_rdata), .if_instr(w_if_instr),
    .if_opcode(w_if_opcode), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4),
    .if_valid(w_if_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(if_valid), 32'd1);
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_instr"}, if_instr, e.instr);
      chk({tag, "_pc4"}, if_pc_plus4, e.pc + 32'd4);
      chk({tag, "_opc"}, 32'(if_opcode), 32'(e.instr[31:26]));
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
    chk({tag, "_opc"}, 32'(if_opcode), 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    branch_target = 32'h0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    chk_bubble("rst");
    chk("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_req", 32'(w_imem_req), 32'd0);

    // START lasts one cycle, then fetching begins at RESET_PC.
    rst = 1'b0;
    tick();
    chk("start_req", 32'(imem_req), 32'd1);
    chk("start_addr", imem_addr, 32'h0);
    chk("start_valid", 32'(if_valid), 32'd0);
    push(32'h0); tick(); pop_check("lw");
    chk("lw_opcode", 32'(if_opcode), 32'b100011);
    chk("wrap0", w_if_pc, 32'hFFFF_FFFC);
    push(32'h4); tick(); pop_check("sw");
    chk("sw_opcode", 32'(if_opcode), 32'b101011);
    chk("wrap1", w_if_pc, 32'h0);

    // Memory not ready for three cycles at pc=8.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bubble("nrdy");
      chk("nrdy_addr", imem_addr, 32'h8);
    end
    imem_ready = 1'b1;
    push(32'h8); tick(); pop_check("after_nrdy");
    chk("wrap2", w_if_pc, 32'h4);
    chk("wrap2_valid", 32'(w_if_valid), 32'd1);
    push(32'hC); tick(); pop_check("w_c");

    // Stall for two cycles while the word at 0x10 is returned.
    stall = 1'b1;
    tick();
    chk("hold1_req", 32'(imem_req), 32'd0);
    chk("hold1_pc", if_pc, 32'hC);
    chk("hold1_valid", 32'(if_valid), 32'd1);
    tick();
    chk("hold2_req", 32'(imem_req), 32'd0);
    chk("hold2_pc", if_pc, 32'hC);
    stall = 1'b0;
    push(32'h10); tick(); pop_check("unhold");
    push(32'h14); tick(); pop_check("w_14");
    push(32'h18); tick(); pop_check("w_18");
    push(32'h1C); tick(); pop_check("w_1c");

    // Redirect at pc=0x20 to an unaligned target.
    branch_taken = 1'b1; branch_target = 32'h42;
    tick();
    chk_bubble("br");
    chk("br_addr", imem_addr, 32'h40);
    chk("br_req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0;
    push(32'h40); tick(); pop_check("br_tgt");

    // Redirect together with stall while fetching.
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h80;
    tick();
    chk_bubble("brst");
    chk("brst_addr", imem_addr, 32'h80);
    branch_taken = 1'b0; stall = 1'b0;
    push(32'h80); tick(); pop_check("brst_tgt");

    // Redirect together with stall while a word is held.
    stall = 1'b1;
    tick();
    chk("hbr_req", 32'(imem_req), 32'd0);
    chk("hbr_pc", if_pc, 32'h80);
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    chk_bubble("hbr");
    chk("hbr_addr", imem_addr, 32'h100);
    chk("hbr_req2", 32'(imem_req), 32'd1);
    branch_taken = 1'b0; stall = 1'b0;
    push(32'h100); tick(); pop_check("hbr_tgt");
    push(32'h104); tick(); pop_check("w_104");

    // Not ready while stalled: nothing moves.
    imem_ready = 1'b0; stall = 1'b1;
    tick();
    chk("nrst_pc", if_pc, 32'h104);
    chk("nrst_valid", 32'(if_valid), 32'd1);
    chk("nrst_addr", imem_addr, 32'h108);

    // Reset while holding a word: the held word is lost.
    imem_ready = 1'b1;
    tick();
    chk("rh_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    tick();
    chk_bubble("rh");
    chk("rh_req2", 32'(imem_req), 32'd0);
    chk("rh_addr", imem_addr, 32'h0);
    chk("rh_pc", if_pc, 32'h0);
    rst = 1'b0; stall = 1'b0;
    tick();
    chk("rh_start_valid", 32'(if_valid), 32'd0);
    chk("rh_start_addr", imem_addr, 32'h0);
    push(32'h0); tick(); pop_check("rh_lw");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
